// File: rtl/usbls_tx_token_gen.sv
// usbls_tx_token_gen: low-speed USB token packet body serializer.
// Emits PID, ~PID, address, endpoint and CRC5 LSB-first, one bit per
// valid/ready handshake. SYNC and EOP are added by the downstream stage.
// Optional build macro USBLS_TX_TOKEN_SOF_EN adds the tok_frame port and
// an 11-bit frame-number phase used in place of ADDR/ENDP for SOF tokens.
`timescale 1ns/1ps

module usbls_tx_token_gen #(
  parameter int ADDR_W = 7,
  parameter int ENDP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [3:0]        tok_pid,
  input  logic [ADDR_W-1:0] tok_addr,
  input  logic [ENDP_W-1:0] tok_endp,
`ifdef USBLS_TX_TOKEN_SOF_EN
  input  logic [10:0]       tok_frame,
`endif
  input  logic              tok_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              busy
);

  localparam int PKT_BITS = 8 + ADDR_W + ENDP_W + 5;
  localparam int CNT_W    = $clog2(PKT_BITS);

  localparam logic [CNT_W-1:0] PID_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] ENDP_LAST  = CNT_W'(ENDP_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(10);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(4);
  localparam logic [4:0]       CRC_SEED   = 5'b11111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PID   = 3'd1,
    ADDR  = 3'd2,
    ENDP  = 3'd3,
    FRAME = 3'd4,
    CRC   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [4:0]        crc;
  logic [7:0]        pid_sr;
  logic [ADDR_W-1:0] addr_sr;
  logic [ENDP_W-1:0] endp_sr;
`ifdef USBLS_TX_TOKEN_SOF_EN
  logic [10:0]       frame_sr;
  logic              sof;
`endif
  logic              accept;
  logic              adv;

  // One step of the USB CRC5 LFSR (x^5 + x^2 + 1) for a single data bit.
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = b ^ c[4];
    return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  assign tok_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state != IDLE);
  assign accept    = tok_valid && tok_ready && !tok_abort;
  assign adv       = out_valid && out_ready;
  assign out_last  = (state == CRC) && (cnt == CRC_LAST);

  // Current serial bit: head of the active field shift register, or the
  // inverted CRC MSB during the CRC phase (CRC register shifts left).
  always_comb begin
    out_bit = 1'b0;
    case (state)
      PID:     out_bit = pid_sr[0];
      ADDR:    out_bit = addr_sr[0];
      ENDP:    out_bit = endp_sr[0];
`ifdef USBLS_TX_TOKEN_SOF_EN
      FRAME:   out_bit = frame_sr[0];
`endif
      CRC:     out_bit = ~crc[4];
      default: out_bit = 1'b0;
    endcase
  end

  // State and bit-counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: counter runs within a field and wraps on each phase change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = PID;
      end
      PID: if (adv) begin
        if (cnt == PID_LAST) begin
          cnt_nxt = '0;
`ifdef USBLS_TX_TOKEN_SOF_EN
          state_nxt = sof ? FRAME : ADDR;
`else
          state_nxt = ADDR;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ADDR: if (adv) begin
        if (cnt == ADDR_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ENDP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ENDP: if (adv) begin
        if (cnt == ENDP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = CRC;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef USBLS_TX_TOKEN_SOF_EN
      FRAME: if (adv) begin
        if (cnt == FRAME_LAST) begin
          cnt_nxt   = '0;
          state_nxt = CRC;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      CRC: if (adv) begin
        if (cnt == CRC_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    if (tok_abort) begin
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end
  end

  // CRC register: accumulates over the payload fields, then shifts out;
  // re-seeded on reset, abort and after the final bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= CRC_SEED;
    end else if (tok_abort) begin
      crc <= CRC_SEED;
    end else if (adv) begin
      case (state)
        ADDR, ENDP, FRAME: crc <= crc5_step(crc, out_bit);
        CRC:               crc <= (cnt == CRC_LAST) ? CRC_SEED : {crc[3:0], 1'b0};
        default:           crc <= crc;
      endcase
    end
  end

  // Field shift registers: loaded on acceptance, shifted right per accepted bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      pid_sr   <= {~tok_pid, tok_pid};
      addr_sr  <= tok_addr;
      endp_sr  <= tok_endp;
`ifdef USBLS_TX_TOKEN_SOF_EN
      frame_sr <= tok_frame;
      sof      <= (tok_pid == 4'b0101);
`endif
    end else if (adv) begin
      case (state)
        PID:     pid_sr   <= pid_sr >> 1;
        ADDR:    addr_sr  <= addr_sr >> 1;
        ENDP:    endp_sr  <= endp_sr >> 1;
`ifdef USBLS_TX_TOKEN_SOF_EN
        FRAME:   frame_sr <= frame_sr >> 1;
`endif
        default: pid_sr   <= pid_sr;
      endcase
    end
  end

endmodule

// File: tb/tb_usbls_tx_token_gen.sv
// Self-checking bench for usbls_tx_token_gen: default-width DUT (7/4) and a
// narrow DUT (3/2), randomized tokens and stalls against a packet-level model.
`timescale 1ns/1ps

module tb_usbls_tx_token_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tok_valid;
  logic        tok_abort;
  logic        out_ready;
  logic        sel;
  logic [3:0]  tok_pid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [10:0] tok_frame;

  logic a_tok_valid, a_tok_ready, a_out_valid, a_out_bit, a_out_last, a_busy;
  logic b_tok_valid, b_tok_ready, b_out_valid, b_out_bit, b_out_last, b_busy;
  logic m_ready, m_ov, m_bit, m_last, m_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign a_tok_valid = tok_valid & ~sel;
  assign b_tok_valid = tok_valid & sel;
  assign m_ready = sel ? b_tok_ready : a_tok_ready;
  assign m_ov    = sel ? b_out_valid : a_out_valid;
  assign m_bit   = sel ? b_out_bit   : a_out_bit;
  assign m_last  = sel ? b_out_last  : a_out_last;
  assign m_busy  = sel ? b_busy      : a_busy;

  usbls_tx_token_gen #(.ADDR_W(7), .ENDP_W(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .tok_valid (a_tok_valid),
    .tok_ready (a_tok_ready),
    .tok_pid   (tok_pid),
    .tok_addr  (tok_addr),
    .tok_endp  (tok_endp),
`ifdef USBLS_TX_TOKEN_SOF_EN
    .tok_frame (tok_frame),
`endif
    .tok_abort (tok_abort),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_bit   (a_out_bit),
    .out_last  (a_out_last),
    .busy      (a_busy)
  );

  usbls_tx_token_gen #(.ADDR_W(3), .ENDP_W(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .tok_valid (b_tok_valid),
    .tok_ready (b_tok_ready),
    .tok_pid   (tok_pid),
    .tok_addr  (tok_addr[2:0]),
    .tok_endp  (tok_endp[1:0]),
`ifdef USBLS_TX_TOKEN_SOF_EN
    .tok_frame (tok_frame),
`endif
    .tok_abort (tok_abort),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_bit   (b_out_bit),
    .out_last  (b_out_last),
    .busy      (b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Packet model: bit i of 'bits' is the i-th transmitted bit.
  function automatic void model(input logic [3:0] pid, input logic [6:0] addr,
                                input logic [3:0] endp, input logic [10:0] frame,
                                input int aw, input int ew,
                                output logic [31:0] bits, output int n);
    logic [4:0]  c;
    logic [7:0]  pb;
    logic [15:0] fld;
    logic        b;
    logic        fb;
    bit          is_sof;
    int          fn;
    bits = '0;
    n    = 0;
    c    = 5'b11111;
    pb   = {~pid, pid};
    for (int i = 0; i < 8; i++) begin
      b = pb[0];
      pb = pb >> 1;
      bits = bits | (32'(b) << n);
      n++;
    end
    is_sof = 1'b0;
`ifdef USBLS_TX_TOKEN_SOF_EN
    is_sof = (pid == 4'b0101);
`endif
    if (is_sof) begin
      fld = {5'b0, frame};
      fn  = 11;
    end else begin
      fld = (16'(addr) & ((16'd1 << aw) - 16'd1)) |
            ((16'(endp) & ((16'd1 << ew) - 16'd1)) << aw);
      fn  = aw + ew;
    end
    for (int i = 0; i < fn; i++) begin
      b = fld[0];
      fld = fld >> 1;
      bits = bits | (32'(b) << n);
      n++;
      fb = b ^ c[4];
      c = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    for (int i = 0; i < 5; i++) begin
      b = ~c[4];
      c = c << 1;
      bits = bits | (32'(b) << n);
      n++;
    end
  endfunction

  // Send one token on the selected DUT and check the whole packet.
  task automatic run_pkt(input string tag, input logic [3:0] pid, input logic [6:0] addr,
                         input logic [3:0] endp, input logic [10:0] frame,
                         input bit stall, output logic [31:0] got);
    logic [31:0] exp;
    int exp_n, n, last_at, n_last, cyc, drops, unstable;
    logic pbit, plast;
    bit stalled;
    model(pid, addr, endp, frame, sel ? 3 : 7, sel ? 2 : 4, exp, exp_n);
    cyc = 0;
    while (!m_ready && cyc < 50) begin
      step;
      cyc++;
    end
    check({tag, "_rdy"}, 32'(m_ready), 1);
    tok_pid = pid; tok_addr = addr; tok_endp = endp; tok_frame = frame;
    tok_valid = 1'b1;
    step;
    tok_valid = 1'b0;
    tok_pid = 4'($urandom); tok_addr = 7'($urandom);
    tok_endp = 4'($urandom); tok_frame = 11'($urandom);
    check({tag, "_lat_vld"}, 32'(m_ov), 1);
    check({tag, "_first"}, 32'(m_bit), 32'(pid[0]));
    got = '0; n = 0; last_at = -1; n_last = 0; cyc = 0;
    drops = 0; unstable = 0; stalled = 1'b0; pbit = 1'b0; plast = 1'b0;
    while (n < exp_n && cyc < 1000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!m_ov) drops++;
      if (stalled && (m_bit !== pbit || m_last !== plast)) unstable++;
      if (m_ov && out_ready) begin
        got = got | (32'(m_bit) << n);
        if (m_last) begin
          n_last++;
          last_at = n;
        end
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pbit = m_bit;
        plast = m_last;
      end
      step;
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, "_len"}, 32'(n), 32'(exp_n));
    check({tag, "_bits"}, got, exp);
    check({tag, "_last_pos"}, 32'(last_at), 32'(exp_n - 1));
    check({tag, "_last_cnt"}, 32'(n_last), 1);
    check({tag, "_vld_drops"}, 32'(drops), 0);
    check({tag, "_stall_stable"}, 32'(unstable), 0);
    check({tag, "_gap_vld"}, 32'(m_ov), 0);
    check({tag, "_gap_rdy"}, 32'(m_ready), 1);
    check({tag, "_gap_busy"}, 32'(m_busy), 0);
  endtask

  // Accept a token and advance k bits with no stalls; bit k is then presented.
  task automatic start_partial(input logic [3:0] pid, input logic [6:0] addr,
                               input logic [3:0] endp, input int k);
    tok_pid = pid; tok_addr = addr; tok_endp = endp;
    tok_valid = 1'b1;
    out_ready = 1'b1;
    step;
    tok_valid = 1'b0;
    repeat (k) step;
  endtask

  initial begin
    logic [31:0] got, got_ref;
    rst_n = 1'b0; tok_valid = 1'b0; tok_abort = 1'b0; out_ready = 1'b1; sel = 1'b0;
    tok_pid = '0; tok_addr = '0; tok_endp = '0; tok_frame = '0;
    step;
    step;
    check("rst_tok_ready", 32'(a_tok_ready), 1);
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_bit", 32'(a_out_bit), 0);
    check("rst_out_last", 32'(a_out_last), 0);
    check("rst_busy", 32'(a_busy), 0);
    rst_n = 1'b1;
    step;

    run_pkt("setup", 4'b1101, 7'h00, 4'h0, 11'h0, 1'b0, got);
    check("setup_bytes", got, 32'h0010002D);

    run_pkt("in", 4'b1001, 7'h15, 4'hE, 11'h0, 1'b0, got);
    check("in_pid_byte", 32'(got[7:0]), 32'h69);
    check("in_crc_field", 32'({got[19], got[20], got[21], got[22], got[23]}), 32'b10111);

    run_pkt("out_ref", 4'b0001, 7'h7F, 4'hF, 11'h0, 1'b0, got_ref);
    run_pkt("out_stall", 4'b0001, 7'h7F, 4'hF, 11'h0, 1'b1, got);
    check("out_same_seq", got, got_ref);

    // Abort at bit 10 with a new request already pending.
    start_partial(4'b1001, 7'h15, 4'hE, 10);
    check("ab_pre_vld", 32'(a_out_valid), 1);
    tok_abort = 1'b1; tok_valid = 1'b1;
    tok_pid = 4'b0001; tok_addr = 7'h3A; tok_endp = 4'h5;
    step;
    tok_abort = 1'b0;
    check("ab_vld", 32'(a_out_valid), 0);
    check("ab_last", 32'(a_out_last), 0);
    check("ab_busy", 32'(a_busy), 0);
    check("ab_rdy", 32'(a_tok_ready), 1);
    run_pkt("ab_new", 4'b0001, 7'h3A, 4'h5, 11'h0, 1'b0, got);

    // Reset pulse at bit 17.
    start_partial(4'b1101, 7'h55, 4'h3, 17);
    rst_n = 1'b0;
    step;
    check("mr_tok_ready", 32'(a_tok_ready), 1);
    check("mr_out_valid", 32'(a_out_valid), 0);
    check("mr_out_bit", 32'(a_out_bit), 0);
    check("mr_out_last", 32'(a_out_last), 0);
    check("mr_busy", 32'(a_busy), 0);
    rst_n = 1'b1;
    step;
    check("mr_rdy_after", 32'(a_tok_ready), 1);
    run_pkt("mr_new", 4'b1101, 7'h2B, 4'h9, 11'h0, 1'b0, got);

`ifdef USBLS_TX_TOKEN_SOF_EN
    run_pkt("sof", 4'b0101, 7'h11, 4'h2, 11'h001, 1'b0, got);
`endif

    for (int i = 0; i < 12; i++) begin
      run_pkt("rnd", 4'($urandom), 7'($urandom), 4'($urandom), 11'($urandom),
              1'($urandom_range(0, 1)), got);
    end

    sel = 1'b1;
    step;
    run_pkt("nb_in", 4'b1001, 7'h05, 4'h2, 11'h0, 1'b0, got);
    for (int i = 0; i < 4; i++) begin
      run_pkt("nb_rnd", 4'($urandom), 7'($urandom), 4'($urandom), 11'($urandom),
              1'($urandom_range(0, 1)), got);
    end
    sel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
